multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Main control FSM for the multicycle CPU. Sequences fetch/decode/execute/memory/writeback
//   and drives datapath selects plus the three PC write-enable terms consumed by the PC
//   write-enable combiner (pc_en = pc_write & ((zero & if_zero) | (!zero & if_nonzero))).
//   Stalls on a memory ready handshake; a timeout counter flags hung bus cycles.
// PARAMETERS
//   MEM_TIMEOUT  255  max cycles waiting for mem_ready before bus_error; 0 disables timeout
//   CNT_W        8    width of timeout counter; must hold MEM_TIMEOUT
// PORTS
//   clk                 in   1  system clock, rising edge
//   rst_n               in   1  asynchronous active-low reset
//   run                 in   1  start/continue execution; sampled in IDLE
//   opcode              in   6  instr[31:26] from IR, valid from DECODE onward
//   mem_ready           in   1  memory completes current read/write this cycle
//   pc_write            out  1  PC write master enable
//   pc_write_if_zero    out  1  PC write qualifier when ALU zero=1
//   pc_write_if_nonzero out  1  PC write qualifier when ALU zero=0
//   pc_src              out  2  0=ALU result, 1=ALUOut reg (branch target), 2=jump target
//   iord                out  1  memory address: 0=PC, 1=ALUOut
//   mem_read/mem_write  out  1  memory strobes, held until mem_ready
//   ir_write            out  1  load IR
//   reg_write           out  1  register file write
//   reg_dst             out  1  0=rt, 1=rd
//   mem_to_reg          out  1  0=ALUOut, 1=MDR
//   alu_src_a           out  1  0=PC, 1=A
//   alu_src_b           out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//   alu_op              out  2  0=add, 1=sub, 2=funct field
//   illegal_op          out  1  one-cycle pulse: unknown opcode in DECODE
//   bus_error           out  1  sticky until reset/run: memory timeout occurred
//   state               out  4  current state encoding (debug)
// BEHAVIOUR
//   - Reset: state=IDLE, counter=0, bus_error=0; all outputs 0 (IDLE decodes to all-zero).
//   - Outputs Moore-decoded from state except FETCH PC/IR enables (gated by mem_ready).
//   - PC encoding: unconditional = pc_write,if_zero,if_nonzero all 1; beq = 1,1,0; bne = 1,0,1.
//   - IDLE(0): run=1 -> FETCH, clears bus_error; else stay.
//   - FETCH(1): mem_read=1,iord=0,alu_src_a=0,alu_src_b=1,alu_op=0,pc_src=0. When mem_ready=1:
//     ir_write=1 and PC unconditional write same cycle, -> DECODE; else hold all strobes.
//   - DECODE(2): alu_src_a=0,alu_src_b=3,alu_op=0 (branch target to ALUOut). Next by opcode:
//     000000 R->EXEC_R; 100011 lw / 101011 sw ->MEM_ADDR; 000100 beq / 000101 bne ->BRANCH;
//     000010 j ->JUMP; 001000 addi ->EXEC_I; other -> illegal_op=1, -> FETCH.
//   - EXEC_R(3): alu_src_a=1,alu_src_b=0,alu_op=2 -> ALU_WB. EXEC_I(4): src_a=1,src_b=2,op=0 -> ALU_WB.
//   - ALU_WB(5): reg_write=1,mem_to_reg=0; reg_dst=1 if from EXEC_R else 0 -> FETCH.
//   - MEM_ADDR(6): src_a=1,src_b=2,op=0 -> MEM_RD (lw) or MEM_WR (sw).
//   - MEM_RD(7): mem_read=1,iord=1; mem_ready -> MEM_WB. MEM_WB(8): reg_write=1,mem_to_reg=1,
//     reg_dst=0 -> FETCH. MEM_WR(9): mem_write=1,iord=1; mem_ready -> FETCH.
//   - BRANCH(10): src_a=1,src_b=0,alu_op=1,pc_src=1,pc_write=1; if_zero=beq, if_nonzero=bne -> FETCH.
//   - JUMP(11): pc_src=2, unconditional PC write -> FETCH.
//   - Opcode latched at DECODE exit into internal reg; later states use latched copy.
//   - Timeout: counter clears on entering FETCH/MEM_RD/MEM_WR, increments each wait cycle
//     with mem_ready=0; reaching MEM_TIMEOUT -> bus_error=1, state IDLE, strobes drop next cycle.
//     mem_ready=1 on the same cycle as reaching the limit wins (normal completion).
//   - Async reset mid-cycle of any state: immediate return to IDLE, all outputs 0; no partial writes.
// TESTING
//   1 Reset then run=1, opcode=000000, mem_ready=1 always -> IDLE,FETCH,DECODE,EXEC_R,ALU_WB,FETCH;
//     reg_write=1 only in ALU_WB with reg_dst=1; PC unconditional write exactly once in FETCH.
//   2 lw with mem_ready low 3 cycles in MEM_RD -> mem_read,iord held 4 cycles, then MEM_WB with
//     mem_to_reg=1; sw -> mem_write in MEM_WR, no reg_write anywhere.
//   3 beq then bne -> BRANCH outputs (1,1,0) then (1,0,1), pc_src=1, alu_op=1.
//   4 opcode=111111 -> illegal_op pulse 1 cycle in DECODE, next state FETCH; j -> pc_src=2, (1,1,1).
//   5 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_error=1 after 4 wait cycles, state IDLE,
//     outputs 0; run=1 clears bus_error; mem_ready=1 on 4th cycle -> no error.
//   6 rst_n asserted in MEM_WR mid-wait -> state=IDLE and mem_write=0 without clock edge.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle control FSM and the CPU datapath.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_ctrl_if;
    logic       run;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_if_zero;
    logic       pc_write_if_nonzero;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state;

    modport master (
        input  run, opcode, mem_ready,
        output pc_write, pc_write_if_zero, pc_write_if_nonzero, pc_src, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, illegal_op, bus_error, state
    );

    modport slave (
        output run, opcode, mem_ready,
        input  pc_write, pc_write_if_zero, pc_write_if_nonzero, pc_src, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, illegal_op, bus_error, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: fetch/decode/execute/memory/writeback sequencing,
// datapath select decode, and a memory-wait timeout that raises a sticky bus_error.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_ALU_WB   = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam bit               TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state_q, nxt_state;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       op_q;
    logic             bus_err_q;
    logic             wait_st, timeout_hit, enter_wait;

    function automatic logic is_wait(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // Next-state logic; a timeout overrides everything except same-cycle completion.
    always_comb begin
        nxt_state   = state_q;
        wait_st     = is_wait(state_q);
        timeout_hit = TO_EN && wait_st && !bus.mem_ready && (cnt_q == TO_LAST);
        case (state_q)
            S_IDLE:     if (bus.run) nxt_state = S_FETCH;
            S_FETCH:    if (bus.mem_ready) nxt_state = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:          nxt_state = S_EXEC_R;
                    OP_LW, OP_SW:  nxt_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: nxt_state = S_BRANCH;
                    OP_J:          nxt_state = S_JUMP;
                    OP_ADDI:       nxt_state = S_EXEC_I;
                    default:       nxt_state = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt_state = S_ALU_WB;
            S_ALU_WB:   nxt_state = S_FETCH;
            S_MEM_ADDR: nxt_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) nxt_state = S_MEM_WB;
            S_MEM_WB:   nxt_state = S_FETCH;
            S_MEM_WR:   if (bus.mem_ready) nxt_state = S_FETCH;
            S_BRANCH, S_JUMP: nxt_state = S_FETCH;
            default:    nxt_state = S_IDLE;
        endcase
        if (timeout_hit) nxt_state = S_IDLE;
        enter_wait = is_wait(nxt_state) && (nxt_state != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= nxt_state;
            if (enter_wait)
                cnt_q <= '0;
            else if (wait_st && !bus.mem_ready)
                cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == S_DECODE)
                op_q <= bus.opcode;
            if (timeout_hit)
                bus_err_q <= 1'b1;
            else if (state_q == S_IDLE && bus.run)
                bus_err_q <= 1'b0;
        end
    end

    // Moore output decode; only the FETCH PC/IR enables look at mem_ready.
    always_comb begin
        bus.pc_write            = 1'b0;
        bus.pc_write_if_zero    = 1'b0;
        bus.pc_write_if_nonzero = 1'b0;
        bus.pc_src              = 2'd0;
        bus.iord                = 1'b0;
        bus.mem_read            = 1'b0;
        bus.mem_write           = 1'b0;
        bus.ir_write            = 1'b0;
        bus.reg_write           = 1'b0;
        bus.reg_dst             = 1'b0;
        bus.mem_to_reg          = 1'b0;
        bus.alu_src_a           = 1'b0;
        bus.alu_src_b           = 2'd0;
        bus.alu_op              = 2'd0;
        bus.illegal_op          = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read            = 1'b1;
                bus.alu_src_b           = 2'd1;
                bus.ir_write            = bus.mem_ready;
                bus.pc_write            = bus.mem_ready;
                bus.pc_write_if_zero    = bus.mem_ready;
                bus.pc_write_if_nonzero = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd3;
                case (bus.opcode)
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: bus.illegal_op = 1'b0;
                    default: bus.illegal_op = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'd2;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
            end
            S_ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = (op_q == OP_R);
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a           = 1'b1;
                bus.alu_op              = 2'd1;
                bus.pc_src              = 2'd1;
                bus.pc_write            = 1'b1;
                bus.pc_write_if_zero    = (op_q == OP_BEQ);
                bus.pc_write_if_nonzero = (op_q == OP_BNE);
            end
            S_JUMP: begin
                bus.pc_src              = 2'd2;
                bus.pc_write            = 1'b1;
                bus.pc_write_if_zero    = 1'b1;
                bus.pc_write_if_nonzero = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.bus_error = bus_err_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle checks state, the full control vector
// and bus_error against hand-written expectations.
module tb_multicycle_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
                           EXEC_I = 4'd4, ALU_WB = 4'd5, MEM_ADDR = 4'd6, MEM_RD = 4'd7,
                           MEM_WB = 4'd8, MEM_WR = 4'd9, BRANCH = 4'd10, JUMP = 4'd11;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

    // Control vector: {pcw,if_z,if_nz,pc_src[2],iord,mrd,mwr,irw,regw,rdst,m2r,srca,srcb[2],aluop[2],ill}
    function automatic logic [18:0] mk(input logic pcw, input logic iz, input logic inz,
                                       input logic [1:0] psrc, input logic iord,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] op, input logic ill);
        return {pcw, iz, inz, psrc, iord, mr, mw, irw, rw, rd, m2r, sa, sb, op, ill};
    endfunction

    logic [18:0] c_idle, c_fetch_wait, c_fetch_go, c_decode, c_decode_bad, c_exec_r,
                 c_exec_i, c_wb_r, c_wb_i, c_mem_rd, c_mem_wb, c_mem_wr, c_beq, c_bne, c_jump;

    function automatic logic [18:0] obs_ctl();
        return {bus.pc_write, bus.pc_write_if_zero, bus.pc_write_if_nonzero, bus.pc_src,
                bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check pre-edge outputs, then advance past the edge.
    task automatic cyc(input string tag, input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [18:0] ctl, input logic berr);
        bus.run       = r;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        chk({tag, ".state"}, 32'(bus.state), 32'(st));
        chk({tag, ".ctl"}, 32'(obs_ctl()), 32'(ctl));
        chk({tag, ".berr"}, 32'(bus.bus_error), 32'(berr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        c_idle       = '0;
        c_fetch_wait = mk(0,0,0,2'd0,0,1,0,0,0,0,0,0,2'd1,2'd0,0);
        c_fetch_go   = mk(1,1,1,2'd0,0,1,0,1,0,0,0,0,2'd1,2'd0,0);
        c_decode     = mk(0,0,0,2'd0,0,0,0,0,0,0,0,0,2'd3,2'd0,0);
        c_decode_bad = mk(0,0,0,2'd0,0,0,0,0,0,0,0,0,2'd3,2'd0,1);
        c_exec_r     = mk(0,0,0,2'd0,0,0,0,0,0,0,0,1,2'd0,2'd2,0);
        c_exec_i     = mk(0,0,0,2'd0,0,0,0,0,0,0,0,1,2'd2,2'd0,0);
        c_wb_r       = mk(0,0,0,2'd0,0,0,0,0,1,1,0,0,2'd0,2'd0,0);
        c_wb_i       = mk(0,0,0,2'd0,0,0,0,0,1,0,0,0,2'd0,2'd0,0);
        c_mem_rd     = mk(0,0,0,2'd0,1,1,0,0,0,0,0,0,2'd0,2'd0,0);
        c_mem_wb     = mk(0,0,0,2'd0,0,0,0,0,1,0,1,0,2'd0,2'd0,0);
        c_mem_wr     = mk(0,0,0,2'd0,1,0,1,0,0,0,0,0,2'd0,2'd0,0);
        c_beq        = mk(1,1,0,2'd1,0,0,0,0,0,0,0,1,2'd0,2'd1,0);
        c_bne        = mk(1,0,1,2'd1,0,0,0,0,0,0,0,1,2'd0,2'd1,0);
        c_jump       = mk(1,1,1,2'd2,0,0,0,0,0,0,0,0,2'd0,2'd0,0);

        rst_n = 1'b0;
        bus.run = 1'b1;
        bus.opcode = OP_R;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        cyc("rst_hold", 1, OP_R, 1, IDLE, c_idle, 0);
        rst_n = 1'b1;

        // R-type with memory always ready
        cyc("r.idle",   1, OP_R, 1, IDLE,   c_idle,     0);
        cyc("r.fetch",  0, OP_R, 1, FETCH,  c_fetch_go, 0);
        cyc("r.decode", 0, OP_R, 1, DECODE, c_decode,   0);
        cyc("r.exec",   0, OP_R, 1, EXEC_R, c_exec_r,   0);
        cyc("r.wb",     0, OP_R, 1, ALU_WB, c_wb_r,     0);

        // lw with three stall cycles in MEM_RD
        cyc("lw.fetch",  0, OP_LW, 1, FETCH,    c_fetch_go, 0);
        cyc("lw.decode", 0, OP_LW, 1, DECODE,   c_decode,   0);
        cyc("lw.addr",   0, OP_R,  1, MEM_ADDR, c_exec_i,   0);
        cyc("lw.rd0",    0, OP_R,  0, MEM_RD,   c_mem_rd,   0);
        cyc("lw.rd1",    0, OP_R,  0, MEM_RD,   c_mem_rd,   0);
        cyc("lw.rd2",    0, OP_R,  0, MEM_RD,   c_mem_rd,   0);
        cyc("lw.rd3",    0, OP_R,  1, MEM_RD,   c_mem_rd,   0);
        cyc("lw.wb",     0, OP_R,  1, MEM_WB,   c_mem_wb,   0);

        // sw: memory write, no register write
        cyc("sw.fetch",  0, OP_SW, 1, FETCH,    c_fetch_go, 0);
        cyc("sw.decode", 0, OP_SW, 1, DECODE,   c_decode,   0);
        cyc("sw.addr",   0, OP_R,  1, MEM_ADDR, c_exec_i,   0);
        cyc("sw.wr",     0, OP_R,  1, MEM_WR,   c_mem_wr,   0);

        // beq then bne
        cyc("beq.fetch",  0, OP_BEQ, 1, FETCH,  c_fetch_go, 0);
        cyc("beq.decode", 0, OP_BEQ, 1, DECODE, c_decode,   0);
        cyc("beq.br",     0, OP_R,   1, BRANCH, c_beq,      0);
        cyc("bne.fetch",  0, OP_BNE, 1, FETCH,  c_fetch_go, 0);
        cyc("bne.decode", 0, OP_BNE, 1, DECODE, c_decode,   0);
        cyc("bne.br",     0, OP_R,   1, BRANCH, c_bne,      0);

        // illegal opcode, jump, addi
        cyc("bad.fetch",  0, OP_BAD,  1, FETCH,  c_fetch_go,   0);
        cyc("bad.decode", 0, OP_BAD,  1, DECODE, c_decode_bad, 0);
        cyc("j.fetch",    0, OP_J,    1, FETCH,  c_fetch_go,   0);
        cyc("j.decode",   0, OP_J,    1, DECODE, c_decode,     0);
        cyc("j.jump",     0, OP_R,    1, JUMP,   c_jump,       0);
        cyc("ai.fetch",   0, OP_ADDI, 1, FETCH,  c_fetch_go,   0);
        cyc("ai.decode",  0, OP_ADDI, 1, DECODE, c_decode,     0);
        cyc("ai.exec",    0, OP_R,    1, EXEC_I, c_exec_i,     0);
        cyc("ai.wb",      0, OP_R,    1, ALU_WB, c_wb_i,       0);

        // timeout: four wait cycles in FETCH
        cyc("to.w0", 0, OP_R, 0, FETCH, c_fetch_wait, 0);
        cyc("to.w1", 0, OP_R, 0, FETCH, c_fetch_wait, 0);
        cyc("to.w2", 0, OP_R, 0, FETCH, c_fetch_wait, 0);
        cyc("to.w3", 0, OP_R, 0, FETCH, c_fetch_wait, 0);
        cyc("to.idle0", 0, OP_R, 0, IDLE, c_idle, 1);
        cyc("to.idle1", 1, OP_R, 0, IDLE, c_idle, 1);

        // ready on the last allowed cycle completes normally
        cyc("ok.w0", 0, OP_SW, 0, FETCH, c_fetch_wait, 0);
        cyc("ok.w1", 0, OP_SW, 0, FETCH, c_fetch_wait, 0);
        cyc("ok.w2", 0, OP_SW, 0, FETCH, c_fetch_wait, 0);
        cyc("ok.w3", 0, OP_SW, 1, FETCH, c_fetch_go,   0);
        cyc("ok.decode", 0, OP_SW, 1, DECODE,   c_decode, 0);
        cyc("ok.addr",   0, OP_R,  0, MEM_ADDR, c_exec_i, 0);

        // asynchronous reset in the middle of a MEM_WR wait
        cyc("ar.wr0", 0, OP_R, 0, MEM_WR, c_mem_wr, 0);
        cyc("ar.wr1", 0, OP_R, 0, MEM_WR, c_mem_wr, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.state", 32'(bus.state), 32'(IDLE));
        chk("ar.mem_write", 32'(bus.mem_write), 32'd0);
        chk("ar.ctl", 32'(obs_ctl()), 32'(c_idle));
        @(posedge clk); #1;
        chk("ar.held", 32'(bus.state), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
